// File: rtl/mips_dbg_pkg.sv
// Shared widths, FSM encodings and byte-select helper for the regfile debug dump reader.
package mips_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // idx counts bytes in stream order; msb_first decides which end of the word goes out first.
    function automatic logic [BYTE_W-1:0] select_byte(input logic [WORD_W-1:0] w,
                                                      input logic [1:0]        idx,
                                                      input logic              msb_first);
        logic [1:0]        pos;
        logic [BYTE_W-1:0] b;
        pos = msb_first ? (2'd3 - idx) : idx;
        case (pos)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/word_byte_ser.sv
// Holds one captured register word and presents it a byte at a time.
module word_byte_ser
    import mips_dbg_pkg::*;
#(
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              advance,
    output logic [BYTE_W-1:0] byte_data,
    output logic              last_byte
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        byte_idx;

    // A load always restarts at byte 0, so a new register never inherits a stale index.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word_q   <= word;
            byte_idx <= '0;
        end else if (advance) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign byte_data = select_byte(word_q, byte_idx, MSB_FIRST);
    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks FIRST_REG..LAST_REG on the regfile debug port and streams each word as four bytes.
module regfile_dump_reader
    import mips_dbg_pkg::*;
#(
    parameter int   FIRST_REG = 0,
    parameter int   LAST_REG  = 31,
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [WORD_W-1:0]     dbg_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BYTE_W-1:0]     m_data,
    output logic [REG_ADDR_W-1:0] m_index,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fsm_state
);

    localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

    logic [1:0]        state;
    logic              load;
    logic              xfer;
    logic              last_byte;
    logic [BYTE_W-1:0] ser_byte;
    logic [WORD_W-1:0] cap_word;

    // Handshake: a byte moves on a posedge where m_valid & m_ready; while m_valid & !m_ready
    // the byte, its index and the captured word are held; m_ready is ignored when m_valid=0.
    assign m_valid = (state == ST_SEND);
    assign xfer    = m_valid & m_ready;
    assign load    = (state == ST_ADDR);

    // The debug port does not mask r0, so it is zeroed here.
    assign cap_word = (dbg_addr == '0) ? '0 : dbg_data;

    word_byte_ser #(
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .word      (cap_word),
        .advance   (xfer),
        .byte_data (ser_byte),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dbg_addr <= FIRST_A;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ADDR;
                        dbg_addr <= FIRST_A;
                    end
                end
                ST_ADDR: state <= ST_SEND;
                ST_SEND: begin
                    // LAST_REG terminates the walk, so the 5-bit address never wraps.
                    if (xfer && last_byte) begin
                        if (dbg_addr == LAST_A) begin
                            state <= ST_DONE;
                        end else begin
                            dbg_addr <= dbg_addr + 1'b1;
                            state    <= ST_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    dbg_addr <= FIRST_A;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_data    = m_valid ? ser_byte : '0;
    assign m_index   = m_valid ? dbg_addr : '0;
    assign m_last    = m_valid & last_byte & (dbg_addr == LAST_A);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: three reader instances share one regfile model and clock.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rf [32];

    // a: full dump MSB first, b: r5 only, c: r3 only LSB first
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        m_ready_a = 1'b1, m_ready_b = 1'b1, m_ready_c = 1'b1;
    logic [4:0]  dbg_addr_a, dbg_addr_b, dbg_addr_c;
    logic [31:0] dbg_data_a, dbg_data_b, dbg_data_c;
    logic        m_valid_a, m_valid_b, m_valid_c;
    logic [7:0]  m_data_a, m_data_b, m_data_c;
    logic [4:0]  m_index_a, m_index_b, m_index_c;
    logic        m_last_a, m_last_b, m_last_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [1:0]  fsm_a, fsm_b, fsm_c;

    assign dbg_data_a = rf[dbg_addr_a];
    assign dbg_data_b = rf[dbg_addr_b];
    assign dbg_data_c = rf[dbg_addr_c];

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_index(m_index_a),
        .m_last(m_last_a), .busy(busy_a), .done(done_a), .fsm_state(fsm_a));

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_index(m_index_b),
        .m_last(m_last_b), .busy(busy_b), .done(done_b), .fsm_state(fsm_b));

    regfile_dump_reader #(.FIRST_REG(3), .LAST_REG(3), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .dbg_addr(dbg_addr_c), .dbg_data(dbg_data_c),
        .m_valid(m_valid_c), .m_ready(m_ready_c), .m_data(m_data_c), .m_index(m_index_c),
        .m_last(m_last_c), .busy(busy_c), .done(done_c), .fsm_state(fsm_c));

    // entry = {m_last, m_index, m_data}
    logic [13:0] exp_q_a[$];
    logic [13:0] exp_q_b[$];
    logic [13:0] exp_q_c[$];

    int done_cnt_a = 0;
    always @(negedge clk) if (done_a) done_cnt_a++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bytes4 holds the four bytes in stream order, first byte in [31:24].
    task automatic push_exp(input int sel, input logic [4:0] idx, input logic [31:0] bytes4,
                            input logic last_reg);
        logic [13:0] e;
        for (int k = 0; k < 4; k++) begin
            e = {last_reg && (k == 3), idx, bytes4[31-8*k -: 8]};
            case (sel)
                0:       exp_q_a.push_back(e);
                1:       exp_q_b.push_back(e);
                default: exp_q_c.push_back(e);
            endcase
        end
    endtask

    task automatic push_full_dump(input logic [31:0] r9_word);
        for (int i = 0; i < 32; i++) begin
            if (i == 0)      push_exp(0, 5'(i), 32'h0000_0000, 1'b0);
            else if (i == 9) push_exp(0, 5'(i), r9_word, 1'b0);
            else             push_exp(0, 5'(i), {8'h10, 8'h00, 8'h00, 8'(i)}, i == 31);
        end
    endtask

    // Every presented byte is checked against the queue head, so a stalled byte must stay put.
    always @(negedge clk) begin
        if (!rst && m_valid_a) begin
            tests_run++;
            if (exp_q_a.size() == 0) begin
                tests_failed++;
                $display("FAIL a_stream: got unexpected byte %h idx %0d", m_data_a, m_index_a);
            end else begin
                tests_run--;
                check("a_stream", {18'h0, m_last_a, m_index_a, m_data_a}, {18'h0, exp_q_a[0]});
                if (m_ready_a) void'(exp_q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid_b) begin
            tests_run++;
            if (exp_q_b.size() == 0) begin
                tests_failed++;
                $display("FAIL b_stream: got unexpected byte %h idx %0d", m_data_b, m_index_b);
            end else begin
                tests_run--;
                check("b_stream", {18'h0, m_last_b, m_index_b, m_data_b}, {18'h0, exp_q_b[0]});
                if (m_ready_b) void'(exp_q_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid_c) begin
            tests_run++;
            if (exp_q_c.size() == 0) begin
                tests_failed++;
                $display("FAIL c_stream: got unexpected byte %h idx %0d", m_data_c, m_index_c);
            end else begin
                tests_run--;
                check("c_stream", {18'h0, m_last_c, m_index_c, m_data_c}, {18'h0, exp_q_c[0]});
                if (m_ready_c) void'(exp_q_c.pop_front());
            end
        end
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"},  {27'h0, dbg_addr_a}, 32'd0);
        check({tag, "_valid"}, {31'h0, m_valid_a}, 32'd0);
        check({tag, "_data"},  {24'h0, m_data_a}, 32'd0);
        check({tag, "_index"}, {27'h0, m_index_a}, 32'd0);
        check({tag, "_last"},  {31'h0, m_last_a}, 32'd0);
        check({tag, "_busy"},  {31'h0, busy_a}, 32'd0);
        check({tag, "_done"},  {31'h0, done_a}, 32'd0);
        check({tag, "_state"}, {30'h0, fsm_a}, 32'd0);
    endtask

    initial begin
        int c0, first_valid, done_at, cnt;
        logic wrote, pulsed, seen;

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf[0] = 32'hDEAD_BEEF;

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_a("rst");
        check("rst_addr_b", {27'h0, dbg_addr_b}, 32'd5);
        check("rst_addr_c", {27'h0, dbg_addr_c}, 32'd3);
        check("rst_busy_b", {31'h0, busy_b}, 32'd0);
        check("rst_state_c", {30'h0, fsm_c}, 32'd0);

        // 1: full dump, ready tied high. Cycle 0 is the edge before start rises.
        push_full_dump({8'h10, 8'h00, 8'h00, 8'h09});
        done_cnt_a = 0;
        @(posedge clk); #1;
        c0 = cyc; start_a = 1'b1;
        first_valid = -1; done_at = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (m_valid_a && first_valid < 0) first_valid = cyc - c0;
            if (busy_a) check("t1_busy_during", {30'h0, fsm_a == 2'd0, busy_a}, 32'd1);
            if (done_a) begin done_at = cyc - c0; break; end
        end
        check("t1_first_valid", first_valid, 2);
        // done occupies cycle 5N+1 = 161 and closes at edge 5N+2 = 162
        check("t1_done_cycle", done_at, 161);
        @(posedge clk); #1;
        check("t1_done_end_162", {31'h0, done_a}, 32'd0);
        check("t1_idle_after", {31'h0, busy_a}, 32'd0);
        check("t1_addr_restored", {27'h0, dbg_addr_a}, 32'd0);
        check("t1_q_empty", exp_q_a.size(), 0);
        check("t1_done_cnt", done_cnt_a, 1);

        // 2: backpressure on r5, ready pattern 1,0,0,1
        push_exp(1, 5'd5, {8'h10, 8'h00, 8'h00, 8'h05}, 1'b1);
        @(posedge clk); #1;
        start_b = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            m_ready_b = (k % 4 == 0) || (k % 4 == 3);
            if (done_b) begin seen = 1'b1; break; end
        end
        check("t2_done_seen", {31'h0, seen}, 32'd1);
        check("t2_q_empty", exp_q_b.size(), 0);
        m_ready_b = 1'b1;

        // 3: LSB first on r3
        push_exp(2, 5'd3, {8'h03, 8'h00, 8'h00, 8'h10}, 1'b1);
        @(posedge clk); #1;
        start_c = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            start_c = 1'b0;
            if (done_c) begin seen = 1'b1; break; end
        end
        check("t3_done_seen", {31'h0, seen}, 32'd1);
        @(posedge clk); #1;
        check("t3_done_one_cycle", {31'h0, done_c}, 32'd0);
        check("t3_idle", {31'h0, busy_c}, 32'd0);
        check("t3_q_empty", exp_q_c.size(), 0);

        // 4: start re-pulsed while r7 is streaming
        push_full_dump({8'h10, 8'h00, 8'h00, 8'h09});
        done_cnt_a = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        pulsed = 1'b0; seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (m_valid_a && m_index_a == 5'd7 && !pulsed) begin
                start_a = 1'b1; pulsed = 1'b1;
            end
            if (done_a) begin seen = 1'b1; break; end
        end
        start_a = 1'b0;
        check("t4_done_seen", {31'h0, seen}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("t4_done_cnt", done_cnt_a, 1);
        check("t4_no_restart", {31'h0, busy_a}, 32'd0);
        check("t4_q_empty", exp_q_a.size(), 0);

        // 5: reset while byte 2 of r12 is presented
        for (int i = 0; i < 12; i++) begin
            if (i == 0) push_exp(0, 5'(i), 32'h0000_0000, 1'b0);
            else        push_exp(0, 5'(i), {8'h10, 8'h00, 8'h00, 8'(i)}, 1'b0);
        end
        push_exp(0, 5'd12, {8'h10, 8'h00, 8'h00, 8'h0C}, 1'b0);
        void'(exp_q_a.pop_back());
        done_cnt_a = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (m_valid_a && exp_q_a.size() == 1) begin
                m_ready_a = 1'b0; rst = 1'b1; seen = 1'b1;
                break;
            end
        end
        check("t5_reached_r12_b2", {31'h0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; m_ready_a = 1'b1;
        @(negedge clk);
        check_reset_a("t5");
        check("t5_left_in_q", exp_q_a.size(), 1);
        exp_q_a.delete();
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt_a, 0);

        // 6: restart from r0; r9 rewritten while r8 streams
        push_full_dump(32'hCAFE_0009);
        done_cnt_a = 0;
        @(posedge clk); #1;
        start_a = 1'b1;
        wrote = 1'b0; seen = 1'b0; cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (m_valid_a && m_index_a == 5'd8 && !wrote) begin
                rf[9] = 32'hCAFE_0009; wrote = 1'b1;
            end
            if (done_a) begin seen = 1'b1; break; end
        end
        check("t6_done_seen", {31'h0, seen}, 32'd1);
        check("t6_wrote", {31'h0, wrote}, 32'd1);
        @(posedge clk); #1;
        check("t6_q_empty", exp_q_a.size(), 0);
        check("t6_done_cnt", done_cnt_a, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
